scratchpad_store_drain: RTL

SCRATCHPAD_STORE_DRAIN -- requirements
Module: scratchpad_store_drain

---
 rtl/scratchpad_store_drain.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/scratchpad_store_drain.sv
// Scratchpad store drain: pops store entries from a show-ahead FIFO and writes
// each row as two DRAM words (low half, then high half). Tracks per-matrix row
// coverage and pulses store_done once all rows of a matrix have been written.
module scratchpad_store_drain #(
    parameter int WORD_W       = 32,   // DRAM word and address width
    parameter int BITS_PER_ROW = 64,   // scratchpad row data width (two words)
    parameter int MAT_S_W      = 2,    // matrix-select width
    parameter int ROW_S_W      = 2     // row-select width
) (
    input  logic                                          CLK,
    input  logic                                          RST,
    input  logic                                          dramFIFO_empty,
    input  logic [WORD_W+MAT_S_W+ROW_S_W+BITS_PER_ROW-1:0] dramFIFO_rdata,
    output logic                                          dramFIFO_REN,
    output logic                                          dmem_wen,
    output logic [WORD_W-1:0]                             dmem_addr,
    output logic [WORD_W-1:0]                             dmem_wdata,
    input  logic                                          dmem_wait,
    output logic                                          store_done,
    output logic [MAT_S_W-1:0]                            store_done_mat,
    output logic                                          busy
);

    localparam int ENTRY_W  = WORD_W + MAT_S_W + ROW_S_W + BITS_PER_ROW;
    localparam int NUM_MATS = 1 << MAT_S_W;
    localparam int ROWS     = 1 << ROW_S_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ENTRY_W-1:0]   hold_q, hold_d;
    logic [ROWS-1:0]      mask_q [NUM_MATS];
    logic [ROWS-1:0]      mask_d [NUM_MATS];
    logic                 done_q, done_d;
    logic [MAT_S_W-1:0]   done_mat_q, done_mat_d;

    // Fields of the entry currently being written.
    logic [WORD_W-1:0]    held_addr;
    logic [MAT_S_W-1:0]   held_mat;
    logic [ROW_S_W-1:0]   held_row;
    logic [WORD_W-1:0]    held_lo;
    logic [WORD_W-1:0]    held_hi;
    logic [WORD_W-1:0]    base_addr;

    logic                 pop;
    logic                 wen_c;
    logic [WORD_W-1:0]    addr_c;
    logic [WORD_W-1:0]    wdata_c;
    logic                 hi_accept;
    logic [ROWS-1:0]      row_set;

    assign held_addr = hold_q[ENTRY_W-1 -: WORD_W];
    assign held_mat  = hold_q[BITS_PER_ROW+ROW_S_W +: MAT_S_W];
    assign held_row  = hold_q[BITS_PER_ROW +: ROW_S_W];
    assign held_lo   = hold_q[WORD_W-1:0];
    assign held_hi   = hold_q[BITS_PER_ROW-1 -: WORD_W];
    assign base_addr = {held_addr[WORD_W-1:2], 2'b00};
    assign hi_accept = (state_q == WR_HI) && !dmem_wait;

    // Next-state, FIFO pop and DRAM request generation.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        wen_c   = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        case (state_q)
            IDLE: begin
                if (!dramFIFO_empty) begin
                    pop     = 1'b1;
                    hold_d  = dramFIFO_rdata;
                    state_d = WR_LO;
                end
            end
            WR_LO: begin
                wen_c   = 1'b1;
                addr_c  = base_addr;
                wdata_c = held_lo;
                if (!dmem_wait) begin
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                wen_c   = 1'b1;
                addr_c  = base_addr + WORD_W'(4);
                wdata_c = held_hi;
                if (!dmem_wait) begin
                    // Chain straight into the next entry to avoid an IDLE bubble.
                    if (!dramFIFO_empty) begin
                        pop     = 1'b1;
                        hold_d  = dramFIFO_rdata;
                        state_d = WR_LO;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row-coverage bookkeeping; a full mask raises done for one cycle and clears.
    always_comb begin
        mask_d     = mask_q;
        done_d     = 1'b0;
        done_mat_d = '0;
        row_set    = '0;
        if (hi_accept) begin
            row_set = mask_q[held_mat] | (ROWS'(1) << held_row);
            if (&row_set) begin
                mask_d[held_mat] = '0;
                done_d           = 1'b1;
                done_mat_d       = held_mat;
            end else begin
                mask_d[held_mat] = row_set;
            end
        end
    end

    // State, holding register, masks and done pulse; reset wins over everything.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (RST) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            // NOTE: the mask array is a handful of flops, not a RAM, so it is
            // reset explicitly; a real memory macro could not be cleared here.
            for (int m = 0; m < NUM_MATS; m++) begin
                mask_q[m] <= '0;
            end
            done_q     <= 1'b0;
            done_mat_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            mask_q     <= mask_d;
            done_q     <= done_d;
            done_mat_q <= done_mat_d;
        end
    end

    // Outputs are forced low while reset is asserted.
    assign dramFIFO_REN   = pop & ~RST;
    assign dmem_wen       = wen_c & ~RST;
    assign dmem_addr      = RST ? '0 : addr_c;
    assign dmem_wdata     = RST ? '0 : wdata_c;
    assign store_done     = done_q & ~RST;
    assign store_done_mat = (RST || !done_q) ? '0 : done_mat_q;
    assign busy           = (state_q != IDLE) && !RST;

endmodule
